// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment sequencer.
//   - RISC-V funct3 encodings for loads and stores
//   - lsu_state_e: sequencer FSM states
//   - size_of(): access size in bytes for a funct3 (1, 2 or 4)
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        ST_ALIGNED,
        ST_BYTE,
        RESP
    } lsu_state_e;

    // Reserved encodings 011/110/111 behave as a plain word.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b100: size_of = 3'd1;
            3'b001, 3'b101: size_of = 3'd2;
            default:        size_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load-result formatter.
// Ports:
//   hi, lo  : upper and lower 32-bit memory words ({hi,lo} is the byte window)
//   off     : byte offset of the access within the lower word
//   funct3  : load type; selects size and sign/zero extension
//   result  : extended 32-bit load value
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] lane;

    always_comb begin
        lane = 32'({hi, lo} >> {off, 3'b000});
        case (funct3)
            F3_LB:   result = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   result = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  result = {24'h0, lane[7:0]};
            F3_LHU:  result = {16'h0, lane[15:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/lsu_align_sequencer.sv
// Load/store sequencer in front of a data memory that only supports
// word-aligned LW reads and naturally aligned SB/SH/SW writes. Loads that
// straddle a word boundary take two reads; misaligned stores become a run
// of byte writes. Load extension is done here.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, a split load
// or misaligned store performs no memory cycles and answers with resp_err=1.
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake; accepted when both are
//                                 high at posedge, ready only in IDLE
//   req_write/funct3/addr/wdata : request fields, latched on accept
//   resp_valid/rdata/err        : one-cycle completion pulse and result
//   mem_read/write/addr/wdata/funct3 : registered data memory controls
//   mem_rdata                   : memory read data, sampled at posedge
//   dbg_state                   : current FSM state
module lsu_align_sequencer
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output lsu_state_e            dbg_state
);

    lsu_state_e            state;
    logic [2:0]            r_funct3;
    logic [2:0]            r_size;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_split;
    logic [DATA_W-1:0]     lo_word;
    logic [1:0]            k;

    // Decode of the request currently presented (used only on accept).
    logic [2:0] req_size;
    logic [1:0] req_off;
    logic       req_split;
    logic       req_st_mis;
    logic       trap_now;

    assign req_size   = size_of(req_funct3);
    assign req_off    = req_addr[1:0];
    assign req_split  = ({1'b0, req_off} + req_size) > 3'd4;
    assign req_st_mis = (req_size == 3'd2 && req_off[0]) ||
                        (req_size == 3'd4 && req_off != 2'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = req_write ? req_st_mis : req_split;
`else
    assign trap_now = 1'b0;
`endif

    logic [DM_ADDRESS-1:0] word_addr;
    logic [1:0]            next_k;
    logic [DATA_W-1:0]     ext_result;

    assign word_addr = {r_addr[DM_ADDRESS-1:2], 2'b00};
    assign next_k    = k + 2'd1;
    assign dbg_state = state;

    // In LD_LO the low word is still on mem_rdata; in LD_HI it is in lo_word
    // and mem_rdata carries the upper word.
    lsu_load_extract u_extract (
        .hi     (mem_rdata),
        .lo     ((state == LD_LO) ? mem_rdata : lo_word),
        .off    (r_addr[1:0]),
        .funct3 (r_funct3),
        .result (ext_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b000;
            r_funct3   <= 3'b000;
            r_size     <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_split    <= 1'b0;
            lo_word    <= '0;
            k          <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_funct3  <= req_funct3;
                        r_size    <= req_size;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_split   <= req_split;
                        k         <= 2'd0;
                        if (trap_now) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else if (!req_write) begin
                            state      <= LD_LO;
                            mem_read   <= 1'b1;
                            mem_funct3 <= F3_LW;
                            mem_addr   <= {req_addr[DM_ADDRESS-1:2], 2'b00};
                        end else if (req_st_mis) begin
                            state      <= ST_BYTE;
                            mem_write  <= 1'b1;
                            mem_funct3 <= F3_SB;
                            mem_addr   <= req_addr;
                            mem_wdata  <= {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                        end else begin
                            state      <= ST_ALIGNED;
                            mem_write  <= 1'b1;
                            mem_funct3 <= req_funct3;
                            mem_addr   <= req_addr;
                            mem_wdata  <= req_wdata;
                        end
                    end
                end
                LD_LO: begin
                    lo_word <= mem_rdata;
                    if (r_split) begin
                        state    <= LD_HI;
                        mem_read <= 1'b1;
                        mem_addr <= word_addr + DM_ADDRESS'(4);  // wraps at top
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ext_result;
                        resp_err   <= 1'b0;
                    end
                end
                LD_HI: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= ext_result;
                    resp_err   <= 1'b0;
                end
                ST_ALIGNED: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                ST_BYTE: begin
                    if (k == 2'(r_size - 3'd1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        k         <= next_k;
                        mem_write <= 1'b1;
                        mem_addr  <= r_addr + DM_ADDRESS'(next_k);
                        mem_wdata <= {{(DATA_W-8){1'b0}}, r_wdata[{next_k, 3'b000} +: 8]};
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    resp_err  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_sequencer.sv
// Directed scoreboard bench for lsu_align_sequencer with a byte-array data
// memory model. Expected memory cycles and responses are queued by the
// driver; a negedge monitor pops and compares them.
module tb_lsu_align_sequencer;
    import lsu_pkg::*;

    localparam int MW = 45;  // {write, funct3, addr[8:0], wdata[31:0]}

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    lsu_state_e  dbg_state;

    // ---------------- clock / reset / counters ----------------
    always #5 clk = ~clk;

    int    cyc = 0;
    int    acc_cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    string cur_test = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    lsu_align_sequencer #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- data memory model ----------------
    logic [7:0]  dmem [0:511];
    logic        bd_en = 1'b0;
    logic [8:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    logic [8:0]  ra;

    always_comb begin
        ra        = {mem_addr[8:2], 2'b00};
        mem_rdata = mem_read ? {dmem[ra + 9'd3], dmem[ra + 9'd2], dmem[ra + 9'd1], dmem[ra]} : 32'h0;
    end

    always @(posedge clk) begin
        if (bd_en) begin
            dmem[bd_addr]         <= bd_data[7:0];
            dmem[bd_addr + 9'd1]  <= bd_data[15:8];
            dmem[bd_addr + 9'd2]  <= bd_data[23:16];
            dmem[bd_addr + 9'd3]  <= bd_data[31:24];
        end else if (mem_write) begin
            case (mem_funct3[1:0])
                2'b00: dmem[mem_addr] <= mem_wdata[7:0];
                2'b01: begin
                    dmem[mem_addr]        <= mem_wdata[7:0];
                    dmem[mem_addr + 9'd1] <= mem_wdata[15:8];
                end
                default: begin
                    dmem[mem_addr]        <= mem_wdata[7:0];
                    dmem[mem_addr + 9'd1] <= mem_wdata[15:8];
                    dmem[mem_addr + 9'd2] <= mem_wdata[23:16];
                    dmem[mem_addr + 9'd3] <= mem_wdata[31:24];
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    logic [MW-1:0] exp_mem_q[$];
    logic [32:0]   exp_resp_q[$];
    int            exp_lat_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s [%s]: got %h, expected %h", name, cur_test, got, exp);
    endtask

    always @(negedge clk) begin
        logic [MW-1:0] obs;
        logic [32:0]   r;
        int            lat;
        if (!reset) begin
            if (mem_read || mem_write) begin
                check("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
                obs = {mem_write, mem_funct3, mem_addr, mem_write ? mem_wdata : 32'h0};
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL mem_unexpected [%s]: got %h, expected no memory cycle", cur_test, obs);
                end else begin
                    check("mem_cycle", 64'(obs), 64'(exp_mem_q.pop_front()));
                end
            end
            if (resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL resp_unexpected [%s]: got err=%0b rdata=%h, expected no response", cur_test, resp_err, resp_rdata);
                end else begin
                    r   = exp_resp_q.pop_front();
                    lat = exp_lat_q.pop_front();
                    check("resp_rdata", 64'(resp_rdata), 64'(r[31:0]));
                    check("resp_err", 64'(resp_err), 64'(r[32]));
                    if (lat >= 0) check("latency", 64'(cyc - acc_cyc), 64'(lat));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic exp_mem(input logic w, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        exp_mem_q.push_back({w, f3, a, w ? d : 32'h0});
    endtask

    task automatic issue(input string name, input logic w, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input logic want_resp);
        int n;
        cur_test = name;
        if (want_resp) begin
            exp_resp_q.push_back({exp_err, exp_rd});
            exp_lat_q.push_back(lat);
        end
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        // Scramble the request fields: the sequencer must use its latched copy.
        req_valid = 1'b0; req_write = ~w; req_funct3 = ~f3; req_addr = ~a; req_wdata = ~wd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_mem_q.size() != 0 || exp_resp_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_mem_q.size() + exp_resp_q.size()), 64'd0);
    endtask

    task automatic run(input string name, input logic w, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int lat);
        issue(name, w, f3, a, wd, exp_rd, exp_err, lat, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_funct3", 64'(mem_funct3), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;

        // Aligned and in-word loads
        poke(9'h010, 32'hDEADBEEF);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lw_aligned", 1'b0, F3_LW, 9'h010, 0, 32'hDEADBEEF, 1'b0, 2);

        poke(9'h010, 32'h80FF0000);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lb_013", 1'b0, F3_LB, 9'h013, 0, 32'hFFFFFF80, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lbu_013", 1'b0, F3_LBU, 9'h013, 0, 32'h00000080, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lh_012", 1'b0, F3_LH, 9'h012, 0, 32'hFFFF80FF, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lhu_012", 1'b0, F3_LHU, 9'h012, 0, 32'h000080FF, 1'b0, 2);

        poke(9'h00C, 32'h11223344);
        poke(9'h010, 32'h55667788);
        poke(9'h004, 32'h00000099);
        poke(9'h008, 32'hCAFEBA00);
        poke(9'h000, 32'h12345678);
        exp_mem(1'b0, F3_LW, 9'h00C, 0);
        run("lhu_00e_inword", 1'b0, F3_LHU, 9'h00E, 0, 32'h00001122, 1'b0, 2);

`ifndef LSU_MISALIGN_TRAP_EN
        // Split loads
        exp_mem(1'b0, F3_LW, 9'h00C, 0);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lw_split_00e", 1'b0, F3_LW, 9'h00E, 0, 32'h77881122, 1'b0, 3);
        exp_mem(1'b0, F3_LW, 9'h00C, 0);
        exp_mem(1'b0, F3_LW, 9'h010, 0);
        run("lh_split_00f", 1'b0, F3_LH, 9'h00F, 0, 32'hFFFF8811, 1'b0, 3);

        // Misaligned stores become byte writes
        exp_mem(1'b1, F3_SB, 9'h005, 32'h000000D4);
        exp_mem(1'b1, F3_SB, 9'h006, 32'h000000C3);
        exp_mem(1'b1, F3_SB, 9'h007, 32'h000000B2);
        exp_mem(1'b1, F3_SB, 9'h008, 32'h000000A1);
        run("sw_mis_005", 1'b1, F3_SW, 9'h005, 32'hA1B2C3D4, 32'h0, 1'b0, 5);
        exp_mem(1'b0, F3_LW, 9'h004, 0);
        run("lw_004_after_sw", 1'b0, F3_LW, 9'h004, 0, 32'hB2C3D499, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h008, 0);
        run("lw_008_after_sw", 1'b0, F3_LW, 9'h008, 0, 32'hCAFEBAA1, 1'b0, 2);

        exp_mem(1'b1, F3_SB, 9'h003, 32'h000000EF);
        exp_mem(1'b1, F3_SB, 9'h004, 32'h000000BE);
        run("sh_mis_003", 1'b1, F3_SH, 9'h003, 32'h0000BEEF, 32'h0, 1'b0, 3);
        exp_mem(1'b0, F3_LW, 9'h000, 0);
        run("lw_000_after_sh", 1'b0, F3_LW, 9'h000, 0, 32'hEF345678, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h004, 0);
        run("lw_004_after_sh", 1'b0, F3_LW, 9'h004, 0, 32'hB2C3D4BE, 1'b0, 2);

        // Address wrap: bytes 0x1FF and 0x000
        poke(9'h1FC, 32'h7F000000);
        exp_mem(1'b0, F3_LW, 9'h1FC, 0);
        exp_mem(1'b0, F3_LW, 9'h000, 0);
        run("lh_wrap_1ff", 1'b0, F3_LH, 9'h1FF, 0, 32'h0000787F, 1'b0, 3);
`else
        // Trap build: faults instead of splitting, no memory traffic
        run("trap_lw_split", 1'b0, F3_LW, 9'h00E, 0, 32'h0, 1'b1, -1);
        run("trap_sh_mis", 1'b1, F3_SH, 9'h003, 32'h0000BEEF, 32'h0, 1'b1, -1);
        run("trap_sw_mis", 1'b1, F3_SW, 9'h005, 32'hA1B2C3D4, 32'h0, 1'b1, -1);
        exp_mem(1'b0, F3_LW, 9'h000, 0);
        run("lw_000_untouched", 1'b0, F3_LW, 9'h000, 0, 32'h12345678, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h004, 0);
        run("lw_004_untouched", 1'b0, F3_LW, 9'h004, 0, 32'h00000099, 1'b0, 2);
`endif

        // Aligned stores pass straight through
        exp_mem(1'b1, F3_SW, 9'h020, 32'h0BADF00D);
        run("sw_aligned_020", 1'b1, F3_SW, 9'h020, 32'h0BADF00D, 32'h0, 1'b0, 2);
        exp_mem(1'b1, F3_SH, 9'h022, 32'h00001234);
        run("sh_aligned_022", 1'b1, F3_SH, 9'h022, 32'h00001234, 32'h0, 1'b0, 2);
        exp_mem(1'b1, F3_SB, 9'h021, 32'h000000AA);
        run("sb_021", 1'b1, F3_SB, 9'h021, 32'h000000AA, 32'h0, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h020, 0);
        run("lw_020", 1'b0, F3_LW, 9'h020, 0, 32'h1234AA0D, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h020, 0);
        run("lb_021", 1'b0, F3_LB, 9'h021, 0, 32'hFFFFFFAA, 1'b0, 2);
        exp_mem(1'b0, F3_LW, 9'h020, 0);
        run("f3_011_as_word", 1'b0, 3'b011, 9'h020, 0, 32'h1234AA0D, 1'b0, 2);

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset during the second byte write of a misaligned store
        poke(9'h040, 32'h00000000);
        exp_mem(1'b1, F3_SB, 9'h041, 32'h00000011);
        exp_mem(1'b1, F3_SB, 9'h042, 32'h00000022);
        issue("sw_mis_reset", 1'b1, F3_SW, 9'h041, 32'h44332211, 32'h0, 1'b0, -1, 1'b0);
        @(negedge clk);        // k=0 cycle
        @(negedge clk);        // k=1 cycle
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_mem_write", 64'(mem_write), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_queue", 64'(exp_mem_q.size()), 64'd0);
        exp_mem(1'b0, F3_LW, 9'h040, 0);
        run("lw_040_after_reset", 1'b0, F3_LW, 9'h040, 0, 32'h00221100, 1'b0, 2);
`endif

        repeat (4) @(negedge clk);
        check("final_queues_empty", 64'(exp_mem_q.size() + exp_resp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
